// File: rtl/store_seq.sv
// store_seq: store-accumulator sequencer with direct/indirect addressing and completed-store counter
module store_seq #(
  parameter logic [2:0] STA_OP = 3'b011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic [15:0] data_in,
  input  logic [15:0] mem_rdata,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] store_cnt
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] IRD   = 3'd1;
  localparam logic [2:0] IWAIT = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]  r_state;
  logic [15:0] r_data;
  logic        w_legal;
  assign w_legal = instr[14:12] == STA_OP;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_data    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      store_cnt <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          busy   <= 1'b1;
          r_data <= data_in;
          if (!w_legal) begin
            r_state <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end else if (instr[15]) begin
            r_state  <= IRD;
            mem_rd   <= 1'b1;
            mem_addr <= instr[11:0];
          end else begin
            r_state   <= WR;
            mem_wr    <= 1'b1;
            mem_addr  <= instr[11:0];
            mem_wdata <= data_in;
          end
        end
        IRD: r_state <= IWAIT;
        IWAIT: begin
          // pointer word's top nibble is not part of the address
          r_state   <= WR;
          mem_wr    <= 1'b1;
          mem_addr  <= mem_rdata[11:0];
          mem_wdata <= r_data;
        end
        WR: begin
          r_state   <= DONE;
          done      <= 1'b1;
          store_cnt <= store_cnt + 16'd1;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_store_seq.sv
// tb_store_seq: directed self-checking bench for store_seq
module tb_store_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] mem_rdata = '0;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd, mem_wr, busy, done, err;
  logic [15:0] store_cnt;
  logic [15:0] mem [0:4095];
  int n_tests = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int overlap_cnt = 0;
  logic [11:0] last_waddr = '0;
  logic [15:0] last_wdata = '0;

  store_seq dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .data_in(data_in),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done), .err(err),
    .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) begin
      wr_cnt++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (mem_rd && mem_wr) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic launch(input logic [15:0] ins, input logic [15:0] dat);
    start = 1'b1;
    instr = ins;
    data_in = dat;
    step();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h050] = 16'hF300;
    step(); step();
    rst = 1'b0;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_strobes", {14'd0, mem_rd, mem_wr}, 16'd0);
    check("rst_done_err", {14'd0, done, err}, 16'd0);
    check("rst_addr", {4'd0, mem_addr}, 16'h0000);
    check("rst_wdata", mem_wdata, 16'h0000);
    check("rst_cnt", store_cnt, 16'h0000);
    step();
    // direct store
    launch(16'h3123, 16'hBEEF);
    data_in = 16'h0000;
    check("dir_wr", {14'd0, mem_rd, mem_wr}, 16'h0001);
    check("dir_addr", {4'd0, mem_addr}, 16'h0123);
    check("dir_wdata", mem_wdata, 16'hBEEF);
    check("dir_busy_done", {14'd0, busy, done}, 16'h0002);
    step();
    check("dir_done", {13'd0, done, err, mem_wr}, 16'h0004);
    check("dir_cnt", store_cnt, 16'd1);
    check("dir_hold_addr", {4'd0, mem_addr}, 16'h0123);
    check("dir_hold_wdata", mem_wdata, 16'hBEEF);
    step();
    check("dir_idle", {14'd0, busy, done}, 16'h0000);
    step();
    // indirect store, with a second start in IRD that must be ignored
    launch(16'hB050, 16'h1234);
    check("ind_rd", {14'd0, mem_rd, mem_wr}, 16'h0002);
    check("ind_rd_addr", {4'd0, mem_addr}, 16'h0050);
    start = 1'b1;
    instr = 16'h3777;
    data_in = 16'h9999;
    step();
    start = 1'b0;
    check("ind_wait", {13'd0, busy, mem_rd, mem_wr}, 16'h0004);
    step();
    check("ind_wr", {14'd0, mem_rd, mem_wr}, 16'h0001);
    check("ind_wr_addr", {4'd0, mem_addr}, 16'h0300);
    check("ind_wdata", mem_wdata, 16'h1234);
    step();
    check("ind_done", {13'd0, done, err, mem_wr}, 16'h0004);
    check("ind_cnt", store_cnt, 16'd2);
    step();
    check("ind_idle", {15'd0, busy}, 16'd0);
    check("ind_wr_total", wr_cnt[15:0], 16'd2);
    check("ind_last_addr", {4'd0, last_waddr}, 16'h0300);
    check("ind_last_data", last_wdata, 16'h1234);
    step();
    // illegal opcode
    launch(16'h7001, 16'hAAAA);
    check("ill_done_err", {12'd0, done, err, mem_rd, mem_wr}, 16'h000C);
    check("ill_cnt", store_cnt, 16'd2);
    step();
    check("ill_after", {13'd0, busy, done, err}, 16'h0000);
    check("ill_no_write", wr_cnt[15:0], 16'd2);
    step();
    // reset during IWAIT
    launch(16'hB050, 16'h4321);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmid_out", {12'd0, busy, done, mem_rd, mem_wr}, 16'h0000);
    check("rmid_addr", {4'd0, mem_addr}, 16'h0000);
    check("rmid_cnt", store_cnt, 16'h0000);
    step(); step(); step();
    check("rmid_no_write", wr_cnt[15:0], 16'd2);
    // counter wrap
    force dut.store_cnt = 16'hFFFF;
    step();
    release dut.store_cnt;
    check("wrap_pre", store_cnt, 16'hFFFF);
    launch(16'h3001, 16'h5555);
    check("wrap_wr_addr", {4'd0, mem_addr}, 16'h0001);
    step();
    check("wrap_done", {15'd0, done}, 16'd1);
    check("wrap_cnt", store_cnt, 16'h0000);
    step();
    check("no_overlap", overlap_cnt[15:0], 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
